id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand/data path width.
REQ-002 Parameter CNT_W, default 16, width of the bubble counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-004 The decoder control inputs SHALL be:
- OP  in  4  ALU opcode.
- Sm  in  2  shifter mode.
- Mm  in  2  memory mode.
- ID_load_instr, ID_RF, ID_RW, ID_Data, ID_shift_imm  in  1 each  decoder control bits.
- ID_RF_clear  in  1  0 = decoder emitted NOP/branch/cond-fail.
REQ-005 ID_RnVal, ID_RmVal, ID_RdVal  in  DATA_W each  register file reads; ID_RdVal is store data.
REQ-006 ID_shifter  in  12  IR[11:0].
REQ-007 ID_Rn, ID_Rm, ID_Rd  in  4 each  register numbers.
REQ-008 ID_Rn_used, ID_Rm_used  in  1 each  operand actually read.
REQ-009 flush  in  1  branch taken; kill the instruction in ID.
REQ-010 The registered stage outputs SHALL be:
- EX_OP  out  4.
- EX_Sm, EX_Mm  out  2 each.
- EX_load_instr, EX_RF, EX_RW, EX_Data, EX_shift_imm  out  1 each.
- EX_RnVal, EX_RmVal, EX_RdVal  out  DATA_W each.
- EX_shifter  out  12.
- EX_Rd  out  4.
REQ-011 stall  out  1  combinational; hold PC and IF/ID.
REQ-012 bubble_cnt  out  CNT_W  count of injected bubbles.

Function
REQ-013 All EX_* outputs SHALL update only on the rising edge of clk; latency ID->EX is 1 cycle.
REQ-014 Normal capture (no stall, no flush, ID_RF_clear=1): every EX_* output SHALL take its ID_* counterpart.
REQ-015 If ID_RF_clear=0 the stage SHALL capture a bubble: all EX control bits and OP/Sm/Mm = 0, data and register fields = 0.
REQ-016 Load-use hazard SHALL be detected when EX_load_instr & EX_RF and any of the following holds:
- ID_Rn_used & ID_Rn==EX_Rd
- ID_Rm_used & ID_Rm==EX_Rd
- ID_RW & ID_Rd==EX_Rd
REQ-017 stall SHALL equal hazard & ~flush, evaluated combinationally from registered EX state and current ID inputs.
REQ-018 With stall=1, EX SHALL capture a bubble; the upstream ID inputs are held externally and captured on the following edge.
REQ-019 stall SHALL never assert on two consecutive cycles for the same load, since the bubble clears EX_load_instr.
REQ-020 flush=1 SHALL inject a bubble regardless of hazard or ID_RF_clear; flush has priority over stall.
REQ-021 bubble_cnt SHALL increment by 1 on each edge where a bubble is injected due to stall or flush; decoder NOPs (REQ-015) do not count.
REQ-022 bubble_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-023 rst_n=0 SHALL immediately, independent of clk, force:
- all EX_* outputs and bubble_cnt to 0;
- stall to 0, as a consequence of EX_load_instr=0.
REQ-024 Reset asserted mid-stall SHALL discard the pending bubble; the first edge after deassertion performs a normal capture.

Structure
REQ-025 A shared package cpu_pkg SHALL hold:
- OP constants: SUB 4'b0010, ADD 4'b0100.
- Sm/Mm encodings.
- the bubble control word constant.
REQ-026 Hazard comparison SHALL live in one combinational sub-module, hazard_detect.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset mid-run with EX_OP=4'b0100, EX_RF=1 -> all outputs 0 without a clock edge, bubble_cnt=0.
- ADD: OP=4'b0100, ID_RF=1, ID_RF_clear=1, ID_RnVal=5, ID_Rd=3 -> next edge EX_OP=4'b0100, EX_RF=1, EX_RnVal=5, EX_Rd=3, stall=0.
- LDR Rd=2 (load=1, RF=1) then ADD Rn=2 with Rn_used=1 -> stall=1 for one cycle; EX bubble; bubble_cnt=1; ADD reaches EX one edge later.
- LDR Rd=2 then instruction with Rn=2 but Rn_used=0, Rm=7 -> stall=0, no bubble.
- LDR Rd=2 then STR with Rd=2 (ID_RW=1) plus flush=1 in the same cycle -> stall=0, bubble, bubble_cnt+1.
- CNT_W=2, five consecutive flushes -> bubble_cnt reads 3 and holds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline encodings: ALU opcodes, shifter/memory modes and the
// control word that represents an empty EX slot.
package cpu_pkg;

  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;

  localparam logic [1:0] SM_IMM      = 2'b00;
  localparam logic [1:0] SM_REG_IMM  = 2'b01;
  localparam logic [1:0] SM_REG_REG  = 2'b10;
  localparam logic [1:0] SM_ROT_IMM  = 2'b11;

  localparam logic [1:0] MM_WORD     = 2'b00;
  localparam logic [1:0] MM_BYTE     = 2'b01;
  localparam logic [1:0] MM_HALF     = 2'b10;
  localparam logic [1:0] MM_DOUBLE   = 2'b11;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] sm;
    logic [1:0] mm;
    logic       load_instr;
    logic       rf;
    logic       rw;
    logic       data;
    logic       shift_imm;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the
// register operands of the instruction currently in ID.
module hazard_detect (
  input  logic       ex_load_instr,
  input  logic       ex_rf,
  input  logic [3:0] ex_rd,
  input  logic       id_rn_used,
  input  logic [3:0] id_rn,
  input  logic       id_rm_used,
  input  logic [3:0] id_rm,
  input  logic       id_rw,
  input  logic [3:0] id_rd,
  output logic       hazard
);

  logic rn_hit;
  logic rm_hit;
  logic rd_hit;

  always_comb begin
    rn_hit = id_rn_used && (id_rn == ex_rd);
    rm_hit = id_rm_used && (id_rm == ex_rd);
    rd_hit = id_rw      && (id_rd == ex_rd);
    hazard = ex_load_instr && ex_rf && (rn_hit || rm_hit || rd_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash and a
// saturating count of injected bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        OP,
  input  logic [1:0]        Sm,
  input  logic [1:0]        Mm,
  input  logic              ID_load_instr,
  input  logic              ID_RF,
  input  logic              ID_RW,
  input  logic              ID_Data,
  input  logic              ID_shift_imm,
  input  logic              ID_RF_clear,
  input  logic [DATA_W-1:0] ID_RnVal,
  input  logic [DATA_W-1:0] ID_RmVal,
  input  logic [DATA_W-1:0] ID_RdVal,
  input  logic [11:0]       ID_shifter,
  input  logic [3:0]        ID_Rn,
  input  logic [3:0]        ID_Rm,
  input  logic [3:0]        ID_Rd,
  input  logic              ID_Rn_used,
  input  logic              ID_Rm_used,
  input  logic              flush,
  output logic [3:0]        EX_OP,
  output logic [1:0]        EX_Sm,
  output logic [1:0]        EX_Mm,
  output logic              EX_load_instr,
  output logic              EX_RF,
  output logic              EX_RW,
  output logic              EX_Data,
  output logic              EX_shift_imm,
  output logic [DATA_W-1:0] EX_RnVal,
  output logic [DATA_W-1:0] EX_RmVal,
  output logic [DATA_W-1:0] EX_RdVal,
  output logic [11:0]       EX_shifter,
  output logic [3:0]        EX_Rd,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  ex_ctrl_t            ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   rn_val_q, rn_val_d;
  logic [DATA_W-1:0]   rm_val_q, rm_val_d;
  logic [DATA_W-1:0]   rd_val_q, rd_val_d;
  logic [11:0]         shifter_q, shifter_d;
  logic [3:0]          rd_q, rd_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic                hazard;
  logic                inject;
  logic                squash;

  hazard_detect u_hazard (
    .ex_load_instr (ctrl_q.load_instr),
    .ex_rf         (ctrl_q.rf),
    .ex_rd         (rd_q),
    .id_rn_used    (ID_Rn_used),
    .id_rn         (ID_Rn),
    .id_rm_used    (ID_Rm_used),
    .id_rm         (ID_Rm),
    .id_rw         (ID_RW),
    .id_rd         (ID_Rd),
    .hazard        (hazard)
  );

  // Only stall/flush bubbles are counted; decoder NOPs also squash EX.
  always_comb begin
    stall  = hazard && !flush;
    inject = stall || flush;
    squash = inject || !ID_RF_clear;

    ctrl_d    = '{op: OP, sm: Sm, mm: Mm, load_instr: ID_load_instr, rf: ID_RF,
                  rw: ID_RW, data: ID_Data, shift_imm: ID_shift_imm};
    rn_val_d  = ID_RnVal;
    rm_val_d  = ID_RmVal;
    rd_val_d  = ID_RdVal;
    shifter_d = ID_shifter;
    rd_d      = ID_Rd;
    if (squash) begin
      ctrl_d    = CTRL_BUBBLE;
      rn_val_d  = '0;
      rm_val_d  = '0;
      rd_val_d  = '0;
      shifter_d = '0;
      rd_d      = '0;
    end

    bubble_cnt_d = bubble_cnt_q;
    if (inject && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= CTRL_BUBBLE;
      rn_val_q     <= '0;
      rm_val_q     <= '0;
      rd_val_q     <= '0;
      shifter_q    <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rn_val_q     <= rn_val_d;
      rm_val_q     <= rm_val_d;
      rd_val_q     <= rd_val_d;
      shifter_q    <= shifter_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign EX_OP         = ctrl_q.op;
  assign EX_Sm         = ctrl_q.sm;
  assign EX_Mm         = ctrl_q.mm;
  assign EX_load_instr = ctrl_q.load_instr;
  assign EX_RF         = ctrl_q.rf;
  assign EX_RW         = ctrl_q.rw;
  assign EX_Data       = ctrl_q.data;
  assign EX_shift_imm  = ctrl_q.shift_imm;
  assign EX_RnVal      = rn_val_q;
  assign EX_RmVal      = rm_val_q;
  assign EX_RdVal      = rd_val_q;
  assign EX_shifter    = shifter_q;
  assign EX_Rd         = rd_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; a second instance with a
// 2-bit counter exercises saturation.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int EXW = 4 + 2 + 2 + 5 + 3 * DW + 12 + 4;

  typedef struct packed {
    logic [3:0]    op;
    logic [1:0]    sm;
    logic [1:0]    mm;
    logic          load, rf, rw, data, shimm, rf_clear;
    logic [DW-1:0] rnval, rmval, rdval;
    logic [11:0]   shifter;
    logic [3:0]    rn, rm, rd;
    logic          rn_used, rm_used;
  } id_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] OP;
  logic [1:0] Sm, Mm;
  logic ID_load_instr, ID_RF, ID_RW, ID_Data, ID_shift_imm, ID_RF_clear;
  logic [DW-1:0] ID_RnVal, ID_RmVal, ID_RdVal;
  logic [11:0] ID_shifter;
  logic [3:0] ID_Rn, ID_Rm, ID_Rd;
  logic ID_Rn_used, ID_Rm_used, flush;

  logic [3:0] EX_OP;
  logic [1:0] EX_Sm, EX_Mm;
  logic EX_load_instr, EX_RF, EX_RW, EX_Data, EX_shift_imm;
  logic [DW-1:0] EX_RnVal, EX_RmVal, EX_RdVal;
  logic [11:0] EX_shifter;
  logic [3:0] EX_Rd;
  logic stall;
  logic [15:0] bubble_cnt;

  logic [3:0] s_OP;
  logic [1:0] s_Sm, s_Mm;
  logic s_load, s_RF, s_RW, s_Data, s_shimm;
  logic [DW-1:0] s_RnVal, s_RmVal, s_RdVal;
  logic [11:0] s_shifter;
  logic [3:0] s_Rd;
  logic s_stall;
  logic [1:0] s_cnt;

  int errors = 0;
  int checks = 0;
  logic [EXW-1:0] exp_q[$];
  logic [EXW-1:0] e;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Sm(Sm), .Mm(Mm),
    .ID_load_instr(ID_load_instr), .ID_RF(ID_RF), .ID_RW(ID_RW), .ID_Data(ID_Data),
    .ID_shift_imm(ID_shift_imm), .ID_RF_clear(ID_RF_clear),
    .ID_RnVal(ID_RnVal), .ID_RmVal(ID_RmVal), .ID_RdVal(ID_RdVal), .ID_shifter(ID_shifter),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd), .ID_Rn_used(ID_Rn_used), .ID_Rm_used(ID_Rm_used),
    .flush(flush),
    .EX_OP(EX_OP), .EX_Sm(EX_Sm), .EX_Mm(EX_Mm), .EX_load_instr(EX_load_instr), .EX_RF(EX_RF),
    .EX_RW(EX_RW), .EX_Data(EX_Data), .EX_shift_imm(EX_shift_imm),
    .EX_RnVal(EX_RnVal), .EX_RmVal(EX_RmVal), .EX_RdVal(EX_RdVal), .EX_shifter(EX_shifter),
    .EX_Rd(EX_Rd), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(DW), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Sm(Sm), .Mm(Mm),
    .ID_load_instr(ID_load_instr), .ID_RF(ID_RF), .ID_RW(ID_RW), .ID_Data(ID_Data),
    .ID_shift_imm(ID_shift_imm), .ID_RF_clear(ID_RF_clear),
    .ID_RnVal(ID_RnVal), .ID_RmVal(ID_RmVal), .ID_RdVal(ID_RdVal), .ID_shifter(ID_shifter),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd), .ID_Rn_used(ID_Rn_used), .ID_Rm_used(ID_Rm_used),
    .flush(flush),
    .EX_OP(s_OP), .EX_Sm(s_Sm), .EX_Mm(s_Mm), .EX_load_instr(s_load), .EX_RF(s_RF),
    .EX_RW(s_RW), .EX_Data(s_Data), .EX_shift_imm(s_shimm),
    .EX_RnVal(s_RnVal), .EX_RmVal(s_RmVal), .EX_RdVal(s_RdVal), .EX_shifter(s_shifter),
    .EX_Rd(s_Rd), .stall(s_stall), .bubble_cnt(s_cnt)
  );

  wire [EXW-1:0] ex_vec = {EX_OP, EX_Sm, EX_Mm, EX_load_instr, EX_RF, EX_RW, EX_Data,
                           EX_shift_imm, EX_RnVal, EX_RmVal, EX_RdVal, EX_shifter, EX_Rd};

  function automatic logic [EXW-1:0] ex_of(id_t i);
    return {i.op, i.sm, i.mm, i.load, i.rf, i.rw, i.data, i.shimm,
            i.rnval, i.rmval, i.rdval, i.shifter, i.rd};
  endfunction

  function automatic id_t nop_id();
    id_t i;
    i = '0;
    i.rf_clear = 1'b1;
    return i;
  endfunction

  function automatic id_t ldr(logic [3:0] rd);
    id_t i;
    i = nop_id();
    i.load = 1'b1; i.rf = 1'b1; i.data = 1'b1; i.mm = 2'b00;
    i.op = 4'b0100; i.rn = 4'd1; i.rn_used = 1'b1; i.rnval = 32'h100;
    i.shifter = 12'h004; i.rd = rd;
    return i;
  endfunction

  function automatic id_t alu(logic [3:0] op, logic [3:0] rn, logic rn_used,
                              logic [3:0] rm, logic rm_used, logic [3:0] rd);
    id_t i;
    i = nop_id();
    i.op = op; i.rf = 1'b1; i.sm = 2'b10;
    i.rn = rn; i.rn_used = rn_used; i.rnval = 32'h11 + 32'(rn);
    i.rm = rm; i.rm_used = rm_used; i.rmval = 32'hA0 + 32'(rm);
    i.rd = rd; i.shifter = {8'h00, rm};
    return i;
  endfunction

  task automatic drive(id_t i, logic fl);
    OP = i.op; Sm = i.sm; Mm = i.mm;
    ID_load_instr = i.load; ID_RF = i.rf; ID_RW = i.rw; ID_Data = i.data;
    ID_shift_imm = i.shimm; ID_RF_clear = i.rf_clear;
    ID_RnVal = i.rnval; ID_RmVal = i.rmval; ID_RdVal = i.rdval; ID_shifter = i.shifter;
    ID_Rn = i.rn; ID_Rm = i.rm; ID_Rd = i.rd;
    ID_Rn_used = i.rn_used; ID_Rm_used = i.rm_used;
    flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    id_t a;
    drive(nop_id(), 1'b1);
    exp_q.push_back('0); exp_cnt++;
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL reset_pre_flush: got %h want %h", ex_vec, e); end
    a = alu(4'b0100, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3);
    drive(a, 1'b0);
    exp_q.push_back(ex_of(a));
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL reset_pre_add: got %h want %h", ex_vec, e); end
    checks++;
    if (bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL reset_pre_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_vec !== '0) begin errors++; $display("FAIL reset_async_ex: got %h want 0", ex_vec); end
    checks++;
    if (bubble_cnt !== 16'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_async_cnt_stall: cnt %0d stall %b want 0 0", bubble_cnt, stall);
    end
    exp_cnt = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    id_t a;
    a = alu(4'b0100, 4'd6, 1'b1, 4'd7, 1'b0, 4'd3);
    a.rnval = 32'd5;
    drive(a, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b want 0", stall); end
    exp_q.push_back(ex_of(a));
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL add_capture: got %h want %h", ex_vec, e); end
    checks++;
    if (EX_OP !== 4'b0100 || EX_RF !== 1'b1 || EX_RnVal !== 32'd5 || EX_Rd !== 4'd3) begin
      errors++; $display("FAIL add_fields: op %h rf %b rn %0d rd %0d want 4 1 5 3", EX_OP, EX_RF, EX_RnVal, EX_Rd);
    end
  endtask

  // Load in EX, then a consumer hitting through Rn, Rm or Rd-as-store-data.
  task automatic test_load_use();
    id_t l, c;
    for (int k = 0; k < 3; k++) begin
      l = ldr(4'd2 + 4'(k));
      drive(l, 1'b0);
      exp_q.push_back(ex_of(l));
      tick();
      e = exp_q.pop_front(); checks++;
      if (ex_vec !== e) begin errors++; $display("FAIL lu%0d_ldr: got %h want %h", k, ex_vec, e); end
      case (k)
        0: c = alu(4'b0100, 4'd2, 1'b1, 4'd8, 1'b1, 4'd5);
        1: c = alu(4'b0010, 4'd9, 1'b1, 4'd3, 1'b1, 4'd6);
        default: begin c = nop_id(); c.rw = 1'b1; c.data = 1'b1; c.rd = 4'd4; c.rdval = 32'hBEEF; end
      endcase
      drive(c, 1'b0);
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL lu%0d_stall_on: got %b want 1", k, stall); end
      exp_q.push_back('0); exp_cnt++;
      tick();
      e = exp_q.pop_front(); checks++;
      if (ex_vec !== e) begin errors++; $display("FAIL lu%0d_bubble: got %h want %h", k, ex_vec, e); end
      checks++;
      if (bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL lu%0d_cnt: got %0d want %0d", k, bubble_cnt, exp_cnt); end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL lu%0d_stall_off: got %b want 0", k, stall); end
      exp_q.push_back(ex_of(c));
      tick();
      e = exp_q.pop_front(); checks++;
      if (ex_vec !== e) begin errors++; $display("FAIL lu%0d_replay: got %h want %h", k, ex_vec, e); end
    end
  endtask

  task automatic test_no_hazard();
    id_t l, c;
    l = ldr(4'd2);
    drive(l, 1'b0);
    exp_q.push_back(ex_of(l));
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL nohz_ldr: got %h want %h", ex_vec, e); end
    c = alu(4'b0010, 4'd2, 1'b0, 4'd7, 1'b1, 4'd2);
    drive(c, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL nohz_stall: got %b want 0", stall); end
    exp_q.push_back(ex_of(c));
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL nohz_capture: got %h want %h", ex_vec, e); end
    checks++;
    if (bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL nohz_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
  endtask

  task automatic test_flush_priority();
    id_t l, s;
    l = ldr(4'd2);
    drive(l, 1'b0);
    exp_q.push_back(ex_of(l));
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL flush_ldr: got %h want %h", ex_vec, e); end
    s = nop_id(); s.rw = 1'b1; s.data = 1'b1; s.rd = 4'd2; s.rdval = 32'h1234; s.op = 4'b0100;
    drive(s, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
    exp_q.push_back('0); exp_cnt++;
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL flush_bubble: got %h want %h", ex_vec, e); end
    checks++;
    if (bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
  endtask

  task automatic test_decoder_nop();
    id_t n;
    n = alu(4'b0100, 4'd3, 1'b1, 4'd4, 1'b1, 4'd9);
    n.rf_clear = 1'b0;
    drive(n, 1'b0);
    exp_q.push_back('0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (ex_vec !== e) begin errors++; $display("FAIL nop_bubble: got %h want %h", ex_vec, e); end
    checks++;
    if (bubble_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL nop_cnt: got %0d want %0d", bubble_cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    drive(alu(4'b0100, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3), 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = (k > 3) ? 3 : k;
      checks++;
      if (s_cnt !== 2'(want)) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, s_cnt, want); end
    end
    drive(nop_id(), 1'b0);
  endtask

  initial begin
    drive(nop_id(), 1'b0);
    #12 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ex_vec !== '0 || bubble_cnt !== 16'd0 || stall !== 1'b0) begin
      errors++; $display("FAIL initial_reset: ex %h cnt %0d stall %b want 0", ex_vec, bubble_cnt, stall);
    end
    test_reset();
    test_add();
    test_load_use();
    test_no_hazard();
    test_flush_priority();
    test_decoder_nop();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
